// File: rtl/risc16_regfile_wb_arbiter.sv
// risc16_regfile_wb_arbiter: round-robin arbiter sharing the RiSC-16 regfile write port between ALU and load writeback
module risc16_regfile_wb_arbiter #(
  parameter int WORD_LENGTH  = 16,
  parameter int REG_ADDR_LEN = 3,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hold,
  input  logic                    a_valid,
  input  logic [REG_ADDR_LEN-1:0] a_addr,
  input  logic [WORD_LENGTH-1:0]  a_data,
  output logic                    a_ready,
  input  logic                    m_valid,
  input  logic [REG_ADDR_LEN-1:0] m_addr,
  input  logic [WORD_LENGTH-1:0]  m_data,
  output logic                    m_ready,
  output logic [REG_ADDR_LEN-1:0] wb_addr,
  output logic [WORD_LENGTH-1:0]  wb_data,
  output logic                    wb_wen,
  input  logic [REG_ADDR_LEN-1:0] rd_addr1,
  input  logic [REG_ADDR_LEN-1:0] rd_addr2,
  output logic                    fwd1_hit,
  output logic                    fwd2_hit,
  output logic [WORD_LENGTH-1:0]  fwd_data,
  output logic [CNT_WIDTH-1:0]    wr_count
);
  typedef enum logic {GNT_A, GNT_M} gnt_t;
  gnt_t last_grant;
  logic win_a, win_m, hs, commit;
  logic [REG_ADDR_LEN-1:0] sel_addr;
  logic [WORD_LENGTH-1:0]  sel_data;
  always_comb begin
    win_a    = !rst && !hold && a_valid && (!m_valid || last_grant == GNT_M);
    win_m    = !rst && !hold && m_valid && !win_a;
    a_ready  = win_a;
    m_ready  = win_m;
    hs       = win_a || win_m;
    sel_addr = win_a ? a_addr : m_addr;
    sel_data = win_a ? a_data : m_data;
    // r0 is hardwired to zero: accept the handshake but drop the write
    commit   = hs && (sel_addr != '0);
    fwd1_hit = wb_wen && (wb_addr == rd_addr1);
    fwd2_hit = wb_wen && (wb_addr == rd_addr2);
    fwd_data = wb_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_wen     <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
      wr_count   <= '0;
      last_grant <= GNT_M;
    end else begin
      wb_wen   <= commit;
      wr_count <= wr_count + CNT_WIDTH'(wb_wen);
      if (commit) begin
        wb_addr <= sel_addr;
        wb_data <= sel_data;
      end
      if (hs) last_grant <= win_a ? GNT_A : GNT_M;
    end
  end
endmodule

// File: tb/tb_risc16_regfile_wb_arbiter.sv
// tb_risc16_regfile_wb_arbiter: scoreboard bench for the writeback arbiter, incl. a 2-bit counter instance for wrap
module tb_risc16_regfile_wb_arbiter;
  logic clk = 0, rst = 1, hold = 0;
  logic a_valid = 0, m_valid = 0;
  logic [2:0] a_addr = 0, m_addr = 0, rd_addr1 = 0, rd_addr2 = 0;
  logic [15:0] a_data = 0, m_data = 0;
  logic a_ready, m_ready, wb_wen, fwd1_hit, fwd2_hit;
  logic [2:0] wb_addr;
  logic [15:0] wb_data, fwd_data;
  logic [7:0] wr_count;
  logic a_ready2, m_ready2, wb_wen2, fwd1_hit2, fwd2_hit2;
  logic [2:0] wb_addr2;
  logic [15:0] wb_data2, fwd_data2;
  logic [1:0] wr_count2;
  typedef struct {int due; logic [2:0] a; logic [15:0] d;} wr_t;
  wr_t q[$];
  wr_t e;
  int n_tests = 0, n_fail = 0, cyc = 0, n_commits = 0;
  logic lg_m = 1;
  logic [2:0] last_a = 0;
  logic [15:0] last_d = 0;

  risc16_regfile_wb_arbiter u_dut (
    .clk(clk), .rst(rst), .hold(hold),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data), .m_ready(m_ready),
    .wb_addr(wb_addr), .wb_data(wb_data), .wb_wen(wb_wen),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd_data(fwd_data), .wr_count(wr_count)
  );
  risc16_regfile_wb_arbiter #(.CNT_WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .hold(hold),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready2),
    .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data), .m_ready(m_ready2),
    .wb_addr(wb_addr2), .wb_data(wb_data2), .wb_wen(wb_wen2),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .fwd1_hit(fwd1_hit2), .fwd2_hit(fwd2_hit2), .fwd_data(fwd_data2), .wr_count(wr_count2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // drives one cycle, checks the grant against the round-robin model and records expected writes
  task automatic step(input logic h, input logic av, input logic [2:0] aa, input logic [15:0] ad,
                      input logic mv, input logic [2:0] ma, input logic [15:0] md);
    logic ea, em;
    hold = h; a_valid = av; a_addr = aa; a_data = ad; m_valid = mv; m_addr = ma; m_data = md;
    #1;
    ea = !rst && !h && av && (!mv || lg_m);
    em = !rst && !h && mv && (!av || !lg_m);
    chk("a_ready", a_ready, ea);
    chk("m_ready", m_ready, em);
    chk("ready2", {a_ready2, m_ready2}, {ea, em});
    if (ea) begin
      lg_m = 0;
      if (aa != 0) q.push_back('{cyc + 1, aa, ad});
    end
    if (em) begin
      lg_m = 1;
      if (ma != 0) q.push_back('{cyc + 1, ma, md});
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input int n);
    rst = 1;
    repeat (n) step(0, 1, 3'd2, 16'h1111, 1, 3'd3, 16'h2222);
    rst = 0;
    q.delete();
    n_commits = 0; last_a = 0; last_d = 0; lg_m = 1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      logic ev;
      ev = (q.size() > 0) && (q[0].due == cyc);
      if (q.size() > 0 && q[0].due < cyc) begin
        chk("stale_write", 1, 0);
        void'(q.pop_front());
      end
      chk("wb_wen", wb_wen, ev);
      chk("wr_count", wr_count, n_commits % 256);
      chk("wr_count2", wr_count2, n_commits % 4);
      if (ev) begin
        e = q.pop_front();
        last_a = e.a; last_d = e.d;
      end
      chk("wb_addr", wb_addr, last_a);
      chk("wb_data", wb_data, last_d);
      chk("fwd_data", fwd_data, last_d);
      chk("fwd1_hit", fwd1_hit, ev && rd_addr1 == last_a);
      chk("fwd2_hit", fwd2_hit, ev && rd_addr2 == last_a);
      if (ev) n_commits++;
    end
  end

  initial begin
    @(posedge clk); #1;
    do_reset(2);
    rd_addr1 = 3'd2; rd_addr2 = 3'd3;
    idle(1);
    repeat (4) step(0, 1, 3'd2, 16'hAAAA, 1, 3'd3, 16'h5555);
    idle(2);
    chk("contention_cnt", wr_count, 4);
    rd_addr1 = 3'd1; rd_addr2 = 3'd0;
    step(0, 1, 3'd1, 16'h1234, 0, 0, 0);
    idle(2);
    chk("single_cnt", wr_count, 5);
    step(0, 0, 0, 0, 1, 3'd0, 16'h2356);
    idle(2);
    chk("r0_cnt", wr_count, 5);
    repeat (3) step(1, 1, 3'd4, 16'hBEEF, 1, 3'd5, 16'hCAFE);
    rd_addr1 = 3'd4; rd_addr2 = 3'd5;
    repeat (2) step(0, 1, 3'd4, 16'hBEEF, 1, 3'd5, 16'hCAFE);
    step(1, 1, 3'd6, 16'h0606, 1, 3'd7, 16'h0707);
    idle(1);
    rd_addr1 = 3'd6; rd_addr2 = 3'd6;
    step(0, 1, 3'd6, 16'h6A6A, 1, 3'd6, 16'h6B6B);
    step(0, 1, 3'd6, 16'h6C6C, 1, 3'd6, 16'h6D6D);
    idle(2);
    step(0, 1, 3'd5, 16'h5A5A, 0, 0, 0);
    chk("pre_rst_wen", wb_wen, 1);
    do_reset(1);
    idle(1);
    chk("cancel_wen", wb_wen, 0);
    chk("cancel_cnt", wr_count, 0);
    for (int i = 0; i < 60; i++) begin
      rd_addr1 = 3'($urandom_range(0, 7));
      rd_addr2 = 3'($urandom_range(0, 7));
      step($urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom));
    end
    idle(3);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
